gray_seq_ctrl: RTL
==================

# gray_seq_ctrl

Run/pause/single-step controller with an integrated Gray-code sequencer for the LED counter lab. It replaces the derived-clock scheme with a single-clock prescaler that issues one-cycle count enables. A 4-state FSM driven by start/stop/step push-button levels sequences a WIDTH-bit Gray count onto the LEDs. Sits directly between board buttons and the `led` pins in the lab top level.

## Interface

- `WIDTH`, 3: Gray counter / LED width; minimum 2.
- `DIV`, 50_000_000: clock cycles per automatic advance in RUN; minimum 2; prescaler width is $clog2(DIV).
- `clk` input 1: system clock; all logic in this single domain.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: button level; rising edge requests RUN.
- `stop` input 1: button level; rising edge requests PAUSE, or IDLE when already paused.
- `step` input 1: button level; rising edge requests a single advance.
- `dir` input 1: count direction, sampled at each advance; 1 = up, 0 = down.
- `led` output WIDTH: registered Gray code of the internal binary count.
- `tick` output 1: registered; high for exactly one cycle after each advance.
- `state` output 2: FSM state; IDLE=00, RUN=01, PAUSE=10, STEP=11.

## Operation

- Edge detect: per button, `edge = in & ~in_q`. `in_q` is the previous-cycle sample of the (possibly synchronised) input.
- Edge priority, when edges coincide: stop > step > start. Only the winning edge acts; losers are discarded.
- Internal binary count `bin` is WIDTH bits. `led = bin ^ (bin >> 1)`, registered. Each advance changes exactly one `led` bit.
- Advance rule: `bin <= dir ? bin+1 : bin-1`, modulo 2^WIDTH.
  - Up wrap: bin 7 → 0 (led 100 → 000).
  - Down wrap: bin 0 → 7 (led 000 → 100).
- IDLE:
  - bin = 0, prescaler = 0.
  - start edge → RUN.
  - step edge → STEP.
  - stop edge ignored.
- RUN:
  - Prescaler counts 0..DIV-1.
  - At DIV-1: prescaler → 0 and the count advances.
  - stop edge → PAUSE; prescaler holds its value.
  - step and start edges ignored.
- PAUSE:
  - bin and prescaler held.
  - start edge → RUN; prescaler resumes from its held value.
  - step edge → STEP.
  - stop edge → IDLE; bin and prescaler clear to 0.
- STEP:
  - Lasts one cycle.
  - Advances once using the current `dir`, then → PAUSE.
  - Prescaler untouched; all edges in this cycle are discarded.
- A stop edge in the same cycle as the RUN prescaler wrap: the advance still occurs, and the state goes to PAUSE with prescaler = 0.

## Timing

- Reset (asynchronous, immediate): state=IDLE, bin=0, led=0, tick=0, prescaler=0, all edge/sync registers 0.
- Without synchroniser, an input rising first sampled at edge k:
  - edge is combinationally high in the cycle ending at edge k;
  - `state` shows the new value after edge k.
- Advance latency: `led` and `tick` update on the same clock edge that performs the advance.
- `tick` is high for exactly one cycle.
- From IDLE→RUN at edge k: first advance at edge k+DIV, then every DIV cycles.
- STEP entered at edge k: `led` changes and `tick`=1 after edge k+1; `state`=PAUSE after edge k+1.
- A held button produces one edge only; release produces none.
- Reset deasserting mid-count: the block restarts from IDLE. No partial state survives.

## Configuration

- `GRAY_SEQ_CTRL_SYNC_EN` defined:
  - two-flop synchronisers on `start`, `stop`, `step`, `dir` ahead of edge detect and sampling;
  - all input-to-state latencies increase by exactly 2 cycles.
- Undefined:
  - inputs are used directly and must already be synchronous to `clk`;
  - latencies are as given in Timing.

## Test plan

- Reset → led=000, tick=0, state=00. Assert rst low mid-RUN → all outputs return to these values immediately, before the next clk edge.
- DIV=4, dir=1, start pulse → led sequence 001,011,010,110,111,101,100,000 with tick every 4 cycles; 8th advance wraps to 000.
- DIV=4, dir=0 from IDLE, start → first led=100 (bin 7), then 101. Check exactly one bit toggles per tick.
- RUN, stop pulse → state=10, led frozen for ≥20 cycles. start → next tick occurs after the remaining prescaler cycles, not a full DIV.
- PAUSE, step pulse with led=011 → one cycle state=11, led=010 (dir=1), tick one cycle, then state=10. A second stop → state=00, led=000.
- Simultaneous stop+step+start edges in RUN → PAUSE only. Stop coinciding with prescaler wrap → advance occurs and state=10. Repeat with `GRAY_SEQ_CTRL_SYNC_EN` and check the +2-cycle shift.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Run/pause/single-step controller driving a WIDTH-bit Gray-code count onto
//   the LEDs. A single-clock prescaler issues one advance every DIV cycles
//   while running, replacing the old derived-clock scheme.
//
//   Optional feature macro: GRAY_SEQ_CTRL_SYNC_EN
//     defined   -> two-flop synchronisers on start/stop/step/dir. Every
//                  input-to-state latency grows by two cycles.
//     undefined -> inputs are used directly and must be synchronous to clk.
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   start in   button level, rising edge requests RUN
//   stop  in   button level, rising edge requests PAUSE (IDLE when paused)
//   step  in   button level, rising edge requests a single advance
//   dir   in   count direction sampled at each advance (1 = up, 0 = down)
//   led   out  registered Gray code of the internal binary count
//   tick  out  registered, high for one cycle after each advance
//   state out  IDLE=00, RUN=01, PAUSE=10, STEP=11
module gray_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic [1:0]       state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  // Button bus ordering: {dir, step, stop, start}
  logic [3:0] btn;

`ifdef GRAY_SEQ_CTRL_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dir, step, stop, start};
      sync2_q <= sync1_q;
    end
  end

  assign btn = sync2_q;
`else
  assign btn = {dir, step, stop, start};
`endif

  // Previous-cycle sample of the three buttons for rising-edge detection
  logic [2:0] btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn[2:0];
    end
  end

  logic rise_start;
  logic rise_stop;
  logic rise_step;
  logic dir_now;

  assign rise_start = btn[0] & ~btn_q[0];
  assign rise_stop  = btn[1] & ~btn_q[1];
  assign rise_step  = btn[2] & ~btn_q[2];
  assign dir_now    = btn[3];

  // Priority stop > step > start: a lower-priority edge only counts when
  // no higher one is present in the same cycle.
  logic win_stop;
  logic win_step;
  logic win_start;

  assign win_stop  = rise_stop;
  assign win_step  = rise_step & ~rise_stop;
  assign win_start = rise_start & ~rise_step & ~rise_stop;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [WIDTH-1:0] led_q;
  logic             tick_q;
  logic             adv;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    presc_d = presc_q;
    adv     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bin_d   = '0;
        presc_d = '0;
        if (win_step) begin
          state_d = S_STEP;
        end else if (win_start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (presc_q == PRESC_MAX) begin
          // The wrap-time advance happens even if stop arrives together
          presc_d = '0;
          adv     = 1'b1;
        end else if (!win_stop) begin
          presc_d = presc_q + 1'b1;
        end
        if (win_stop) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (win_stop) begin
          state_d = S_IDLE;
          bin_d   = '0;
          presc_d = '0;
        end else if (win_step) begin
          state_d = S_STEP;
        end else if (win_start) begin
          state_d = S_RUN;
        end
      end

      S_STEP: begin
        adv     = 1'b1;
        state_d = S_PAUSE;
      end

      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      bin_d = dir_now ? bin_q + 1'b1 : bin_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      presc_q <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      presc_q <= presc_d;
      // Gray output follows the next count so it moves on the advancing edge
      led_q   <= bin_d ^ (bin_d >> 1);
      tick_q  <= adv;
    end
  end

  assign led   = led_q;
  assign tick  = tick_q;
  assign state = state_q;

endmodule
